// File: rtl/load_store_unit.sv
// Sequential RV32I load/store unit: word-aligned memory accesses, sub-word stores via read-modify-write.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned H/W accesses into 1-cycle fault responses.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_fault,
  output logic [ADDR_W-1:0] o_mem_Addr,
  output logic [31:0]       o_mem_Wd,
  output logic              o_mem_Wen,
  output logic              o_mem_Ren,
  input  logic [31:0]       i_mem_Rd
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_EXTRACT = 3'd2,
    S_MERGE   = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [31:0]       wd_q, wd_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [4:0]  lane_sh;
  logic [31:0] lane_word;
  logic [15:0] lane_h;
  logic [31:0] ext_data;
  logic [31:0] merge_mask;
  logic [31:0] merge_data;

  assign accept  = i_req_valid & (state_q == S_IDLE) & ~i_rst;
  assign illegal = (i_req_funct3 == 3'b011) | (i_req_funct3[2:1] == 2'b11);

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ((i_req_funct3[1:0] == 2'b01) & i_req_addr[0]) |
                      ((i_req_funct3[1:0] == 2'b10) & (i_req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Halfword accesses use only addr[1] for the lane, so addr[0] is dropped from the shift.
  assign lane_sh   = (f3_q[1:0] == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
  assign lane_word = i_mem_Rd >> lane_sh;
  assign lane_h    = lane_word[15:0];

  always_comb begin
    ext_data   = i_mem_Rd;
    merge_mask = 32'h0000_0000;
    merge_data = 32'h0000_0000;
    case (f3_q[1:0])
      2'b00: begin
        ext_data   = {{24{~f3_q[2] & lane_word[7]}}, lane_word[7:0]};
        merge_mask = 32'h0000_00FF << lane_sh;
        merge_data = {24'h0, wdata_q[7:0]} << lane_sh;
      end
      2'b01: begin
        ext_data   = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
        merge_mask = 32'h0000_FFFF << lane_sh;
        merge_data = {16'h0, wdata_q[15:0]} << lane_sh;
      end
      default: begin
        ext_data   = i_mem_Rd;
        merge_mask = 32'hFFFF_FFFF;
        merge_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = i_req_we;
          f3_d    = i_req_funct3;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          wd_d    = i_req_wdata;
          rdata_d = 32'h0;
          fault_d = illegal | misaligned;
          if (illegal | misaligned)
            state_d = S_DONE;
          else if (i_req_we && (i_req_funct3[1:0] == 2'b10))
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:    state_d = we_q ? S_MERGE : S_EXTRACT;
      S_EXTRACT: begin
        rdata_d = ext_data;
        state_d = S_DONE;
      end
      S_MERGE: begin
        wd_d    = (i_mem_Rd & ~merge_mask) | merge_data;
        state_d = S_WRITE;
      end
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
      wd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      wd_q    <= wd_d;
    end
  end

  // Every output is forced low during reset so an abandoned request cannot leak a strobe.
  assign o_req_ready = (state_q == S_IDLE) & ~i_rst;
  assign o_rsp_valid = (state_q == S_DONE) & ~i_rst;
  assign o_rsp_rdata = i_rst ? 32'h0 : rdata_q;
  assign o_rsp_fault = fault_q & ~i_rst;
  assign o_mem_Addr  = i_rst ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_Wd    = i_rst ? 32'h0 : wd_q;
  assign o_mem_Ren   = (state_q == S_READ) & ~i_rst;
  assign o_mem_Wen   = (state_q == S_WRITE) & ~i_rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model, strobe monitor and a response scoreboard.
// Build with LSU_ALIGN_CHECK_EN defined to exercise the misaligned-fault expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_rd;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_f3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_fault  (rsp_fault),
    .o_mem_Addr   (mem_addr),
    .o_mem_Wd     (mem_wd),
    .o_mem_Wen    (mem_wen),
    .o_mem_Ren    (mem_ren),
    .i_mem_Rd     (mem_rd)
  );

  // Word memory: read data appears the cycle after the Ren cycle.
  logic [31:0] mem [0:63];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
    end else begin
      if (mem_ren) mem_rd <= mem[mem_addr[7:2]];
      if (mem_wen) mem[mem_addr[7:2]] <= mem_wd;
    end
  end

  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          rsp_cnt = 0;
  int          viol    = 0;
  logic [31:0] last_ren_addr = 32'h0;
  logic [31:0] last_wen_addr = 32'h0;
  logic [31:0] last_wd       = 32'h0;
  always @(negedge clk) begin
    if (mem_ren) begin ren_cnt++; last_ren_addr = mem_addr; end
    if (mem_wen) begin wen_cnt++; last_wen_addr = mem_addr; last_wd = mem_wd; end
    if (rsp_valid) rsp_cnt++;
    if (mem_ren && mem_wen) viol++;
    if ((mem_ren || mem_wen) && (mem_addr[1:0] != 2'b00)) viol++;
    if (rst && (mem_ren || mem_wen || rsp_valid || req_ready)) viol++;
  end

  typedef struct {
    logic [31:0] rd;
    logic        fault;
    int          lat;
    int          nren;
    int          nwen;
  } exp_t;
  exp_t exp_q[$];

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] obs_rd;
  logic        obs_fault;
  int          obs_lat;
  int          obs_ren;
  int          obs_wen;
  logic        obs_timeout;

  // Drives one request, scrambles the request inputs right after accept, and captures the response.
  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wdat);
    int r0, w0, n;
    obs_timeout = 1'b1;
    obs_lat = 0; obs_rd = 32'hX; obs_fault = 1'bX;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wdat;
    @(posedge clk); #1;
    r0 = ren_cnt; w0 = wen_cnt;
    req_valid = 1'b0; req_we = ~we; req_f3 = 3'b010; req_addr = ~a; req_wdata = ~wdat;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        obs_lat = i; obs_rd = rsp_rdata; obs_fault = rsp_fault; obs_timeout = 1'b0;
        break;
      end
    end
    #1;
    obs_ren = ren_cnt - r0;
    obs_wen = wen_cnt - w0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_f3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b need 0", req_ready); end
    n_cmp++;
    if ({rsp_valid, rsp_fault, mem_ren, mem_wen} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b need 0000", {rsp_valid, rsp_fault, mem_ren, mem_wen});
    end
    n_cmp++;
    if ({rsp_rdata, mem_addr, mem_wd} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: rdata %h addr %h wd %h need 0", rsp_rdata, mem_addr, mem_wd);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b need 1", req_ready); end
  endtask

  task automatic test_lw;
    exp_t e;
    exp_q.push_back('{rd: 32'hDEADBEEF, fault: 1'b0, lat: 3, nren: 1, nwen: 0});
    send(1'b0, 3'b010, 32'h10, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL lw_timeout: got no response need response"); end
    n_cmp++;
    if ({obs_rd, obs_fault} !== {e.rd, e.fault}) begin
      n_fail++; $display("FAIL lw_data: got %h/%b need %h/%b", obs_rd, obs_fault, e.rd, e.fault);
    end
    n_cmp++;
    if (obs_lat != e.lat) begin n_fail++; $display("FAIL lw_latency: got %0d need %0d", obs_lat, e.lat); end
    n_cmp++;
    if (obs_ren != e.nren || obs_wen != e.nwen || last_ren_addr !== 32'h10) begin
      n_fail++; $display("FAIL lw_strobes: ren %0d wen %0d addr %h need 1/0/00000010", obs_ren, obs_wen, last_ren_addr);
    end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  f3s [8]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b001, 3'b000};
    logic [31:0] as  [8]  = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10, 32'h10, 32'h11};
    logic [31:0] rds [8]  = '{32'hFFFFFFAD, 32'h000000AD, 32'hFFFFDEAD, 32'h0000BEEF,
                              32'hFFFFFFDE, 32'h000000EF, 32'hFFFFBEEF, 32'hFFFFFFBE};
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{rd: rds[k], fault: 1'b0, lat: 3, nren: 1, nwen: 0});
      send(1'b0, f3s[k], as[k], 32'h0);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_timeout !== 1'b0 || {obs_rd, obs_fault} !== {e.rd, e.fault} || obs_lat != e.lat ||
          obs_ren != e.nren || obs_wen != e.nwen) begin
        n_fail++;
        $display("FAIL load_f3_%b_addr_%h: got %h/%b lat %0d ren %0d wen %0d need %h/%b lat %0d ren %0d wen %0d",
                 f3s[k], as[k], obs_rd, obs_fault, obs_lat, obs_ren, obs_wen, e.rd, e.fault, e.lat, e.nren, e.nwen);
      end
    end
  endtask

  task automatic test_misaligned;
    exp_t e;
`ifdef LSU_ALIGN_CHECK_EN
    exp_q.push_back('{rd: 32'h0, fault: 1'b1, lat: 1, nren: 0, nwen: 0});
`else
    exp_q.push_back('{rd: 32'hDEADBEEF, fault: 1'b0, lat: 3, nren: 1, nwen: 0});
`endif
    send(1'b0, 3'b010, 32'h11, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || {obs_rd, obs_fault} !== {e.rd, e.fault} || obs_lat != e.lat ||
        obs_ren != e.nren || obs_wen != e.nwen) begin
      n_fail++;
      $display("FAIL lw_misaligned: got %h/%b lat %0d ren %0d wen %0d need %h/%b lat %0d ren %0d wen %0d",
               obs_rd, obs_fault, obs_lat, obs_ren, obs_wen, e.rd, e.fault, e.lat, e.nren, e.nwen);
    end
  endtask

  task automatic test_illegal;
    logic [2:0] f3s [3] = '{3'b011, 3'b110, 3'b111};
    logic       wes [3] = '{1'b0, 1'b0, 1'b1};
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{rd: 32'h0, fault: 1'b1, lat: 1, nren: 0, nwen: 0});
      send(wes[k], f3s[k], 32'h10, 32'h55AA55AA);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_timeout !== 1'b0 || {obs_rd, obs_fault} !== {e.rd, e.fault} || obs_lat != e.lat ||
          obs_ren != e.nren || obs_wen != e.nwen) begin
        n_fail++;
        $display("FAIL illegal_f3_%b: got %h/%b lat %0d ren %0d wen %0d need %h/%b lat %0d ren %0d wen %0d",
                 f3s[k], obs_rd, obs_fault, obs_lat, obs_ren, obs_wen, e.rd, e.fault, e.lat, e.nren, e.nwen);
      end
    end
  endtask

  task automatic test_sb;
    exp_t e;
    exp_q.push_back('{rd: 32'h0, fault: 1'b0, lat: 4, nren: 1, nwen: 1});
    send(1'b1, 3'b000, 32'h11, 32'h12345677);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || {obs_rd, obs_fault} !== {e.rd, e.fault} || obs_lat != e.lat) begin
      n_fail++; $display("FAIL sb_rsp: got %h/%b lat %0d need %h/%b lat %0d", obs_rd, obs_fault, obs_lat, e.rd, e.fault, e.lat);
    end
    n_cmp++;
    if (obs_ren != e.nren || obs_wen != e.nwen || last_wen_addr !== 32'h10 || last_wd !== 32'hDEAD77EF) begin
      n_fail++; $display("FAIL sb_write: ren %0d wen %0d addr %h wd %h need 1/1/00000010/deadbeef->dead77ef",
                         obs_ren, obs_wen, last_wen_addr, last_wd);
    end
    exp_q.push_back('{rd: 32'hDEAD77EF, fault: 1'b0, lat: 3, nren: 1, nwen: 0});
    send(1'b0, 3'b010, 32'h10, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || obs_rd !== e.rd) begin
      n_fail++; $display("FAIL sb_readback: got %h need %h", obs_rd, e.rd);
    end
    // Restore the preload word through the DUT before the halfword store.
    exp_q.push_back('{rd: 32'h0, fault: 1'b0, lat: 2, nren: 0, nwen: 1});
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || obs_lat != e.lat || obs_wen != e.nwen || last_wd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL sw_restore: lat %0d wen %0d wd %h need %0d/1/deadbeef", obs_lat, obs_wen, last_wd, e.lat);
    end
  endtask

  task automatic test_sh;
    exp_t e;
    exp_q.push_back('{rd: 32'h0, fault: 1'b0, lat: 4, nren: 1, nwen: 1});
    send(1'b1, 3'b001, 32'h12, 32'h0000CAFE);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || {obs_rd, obs_fault} !== {e.rd, e.fault} || obs_lat != e.lat ||
        obs_ren != e.nren || obs_wen != e.nwen || last_wd !== 32'hCAFEBEEF) begin
      n_fail++; $display("FAIL sh_write: got %h/%b lat %0d ren %0d wen %0d wd %h need 0/0 lat 4 ren 1 wen 1 wd cafebeef",
                         obs_rd, obs_fault, obs_lat, obs_ren, obs_wen, last_wd);
    end
    exp_q.push_back('{rd: 32'hCAFEBEEF, fault: 1'b0, lat: 3, nren: 1, nwen: 0});
    send(1'b0, 3'b010, 32'h10, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || obs_rd !== e.rd) begin
      n_fail++; $display("FAIL sh_readback: got %h need %h", obs_rd, e.rd);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    exp_q.push_back('{rd: 32'h0, fault: 1'b0, lat: 2, nren: 0, nwen: 1});
    send(1'b1, 3'b010, 32'h14, 32'h01020304);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || {obs_rd, obs_fault} !== {e.rd, e.fault} || obs_lat != e.lat ||
        obs_ren != e.nren || obs_wen != e.nwen || last_wen_addr !== 32'h14 || last_wd !== 32'h01020304) begin
      n_fail++; $display("FAIL sw_0x14: got %h/%b lat %0d ren %0d wen %0d addr %h wd %h need 0/0 lat 2 ren 0 wen 1 addr 14 wd 01020304",
                         obs_rd, obs_fault, obs_lat, obs_ren, obs_wen, last_wen_addr, last_wd);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_done: got %b need 0", req_ready); end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_done: got %b need 1", req_ready); end
    exp_q.push_back('{rd: 32'h01020304, fault: 1'b0, lat: 3, nren: 1, nwen: 0});
    send(1'b0, 3'b010, 32'h14, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || obs_rd !== e.rd || last_ren_addr !== 32'h14) begin
      n_fail++; $display("FAIL sw_readback: got %h addr %h need %h addr 14", obs_rd, last_ren_addr, e.rd);
    end
  endtask

  task automatic test_reset_mid;
    int   w0, s0, n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h12345677;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0 = wen_cnt; s0 = rsp_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b need 1", req_ready); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (wen_cnt != w0 || rsp_cnt != s0) begin
      n_fail++; $display("FAIL rstmid_abandon: wen %0d rsp %0d need 0/0", wen_cnt - w0, rsp_cnt - s0);
    end
    exp_q.push_back('{rd: 32'hCAFEBEEF, fault: 1'b0, lat: 3, nren: 1, nwen: 0});
    send(1'b0, 3'b010, 32'h10, 32'h0);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs_timeout !== 1'b0 || obs_rd !== e.rd) begin
      n_fail++; $display("FAIL rstmid_word: got %h need %h", obs_rd, e.rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, need finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_subword_loads();
    test_misaligned();
    test_illegal();
    test_sb();
    test_sh();
    test_back_to_back();
    test_reset_mid();
    #1;
    n_cmp++;
    if (viol != 0) begin n_fail++; $display("FAIL strobe_rules: got %0d violations need 0", viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
